// File: rtl/etm_mul_rr_sched_if.sv
// Requester-side bus of the shared ETM multiplier scheduler.
// It carries the operand request channel and the result response channel.
interface etm_mul_rr_sched_if #(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = 2
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [16*NUM_REQ-1:0] req_a;
   logic [16*NUM_REQ-1:0] req_b;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [NUM_REQ-1:0]    rsp_ready;
   logic [31:0]           rsp_c;
   logic [TAG_W-1:0]      rsp_tag;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_c, rsp_tag
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_c, rsp_tag
   );
endinterface

// File: rtl/etm_mul_rr_sched.sv
// Round-robin scheduler sharing one combinational 16x16 ETM multiplier among
// NUM_REQ requesters, with issued-op and small-operand profiling counters.
//
// state  | meaning
// S_IDLE | no op in flight; grant the round-robin winner if any request is valid
// S_MUL  | operands sit on the multiplier inputs; capture the product at the end of the cycle
// S_RESP | result held for the owner; on handshake, grant the next op or return to idle
module etm_mul_rr_sched #(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   etm_mul_rr_sched_if.slave   bus,
   output logic [15:0]         mul_a_o,
   output logic [15:0]         mul_b_o,
   input  logic [31:0]         mul_c_i,
   output logic [15:0]         op_cnt_o,
   output logic [15:0]         small_cnt_o
);
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_RESP} state_t;

   localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
   localparam logic [TAG_W-1:0]   LAST_IDX = TAG_W'(NUM_REQ - 1);

   state_t               state_q;
   logic [TAG_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [TAG_W-1:0]     owner_q;
   logic [15:0]          mul_a_q, mul_b_q;
   logic [31:0]          rsp_c_q;
   logic [TAG_W-1:0]     rsp_tag_q;
   logic [NUM_REQ-1:0]   rsp_valid_q;
   logic [15:0]          op_cnt_q, op_cnt_d;
   logic [15:0]          small_cnt_q, small_cnt_d;

   logic                 hs;
   logic                 found;
   logic                 grant;
   logic [TAG_W-1:0]     win;
   logic [TAG_W-1:0]     idx;
   logic [15:0]          win_a, win_b;
   logic                 small_hit;
   logic [NUM_REQ-1:0]   req_ready_d;

   always_comb begin
      hs    = (state_q == S_RESP) && bus.rsp_ready[owner_q];
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = TAG_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (!found && bus.req_valid[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end

      win_a = '0;
      win_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win == TAG_W'(i)) begin
            win_a = bus.req_a[16*i +: 16];
            win_b = bus.req_b[16*i +: 16];
         end
      end

      grant       = found && ((state_q == S_IDLE) || hs);
      req_ready_d = grant ? (ONE_HOT0 << win) : '0;
      small_hit   = (win_a[15:8] == 8'd0) || (win_b[15:8] == 8'd0);

      rr_ptr_d = rr_ptr_q;
      if (grant) rr_ptr_d = (win == LAST_IDX) ? '0 : win + TAG_W'(1);

      op_cnt_d = op_cnt_q;
      if (grant && (op_cnt_q != 16'hFFFF)) op_cnt_d = op_cnt_q + 16'd1;
      small_cnt_d = small_cnt_q;
      if (grant && small_hit && (small_cnt_q != 16'hFFFF)) small_cnt_d = small_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         rsp_c_q     <= '0;
         rsp_tag_q   <= '0;
         rsp_valid_q <= '0;
         op_cnt_q    <= '0;
         small_cnt_q <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         op_cnt_q    <= op_cnt_d;
         small_cnt_q <= small_cnt_d;
         if (grant) begin
            mul_a_q <= win_a;
            mul_b_q <= win_b;
            owner_q <= win;
         end
         case (state_q)
            S_IDLE: if (grant) state_q <= S_MUL;
            S_MUL: begin
               rsp_c_q     <= mul_c_i;
               rsp_tag_q   <= owner_q;
               rsp_valid_q <= ONE_HOT0 << owner_q;
               state_q     <= S_RESP;
            end
            S_RESP: begin
               if (hs) begin
                  rsp_valid_q <= '0;
                  state_q     <= grant ? S_MUL : S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready = req_ready_d;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_c     = rsp_c_q;
   assign bus.rsp_tag   = rsp_tag_q;
   assign mul_a_o       = mul_a_q;
   assign mul_b_o       = mul_b_q;
   assign op_cnt_o      = op_cnt_q;
   assign small_cnt_o   = small_cnt_q;
endmodule

// File: tb/tb_etm_mul_rr_sched.sv
// Directed bench for etm_mul_rr_sched with an exact behavioural multiplier
// standing in for the ETM datapath.
module tb_etm_mul_rr_sched;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   etm_mul_rr_sched_if #(.NUM_REQ(4), .TAG_W(2)) bus ();

   logic [15:0] mul_a, mul_b, op_cnt, small_cnt;
   logic [31:0] mul_c;
   assign mul_c = 32'(mul_a) * 32'(mul_b);

   etm_mul_rr_sched #(.NUM_REQ(4), .TAG_W(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .mul_a_o     (mul_a),
      .mul_b_o     (mul_b),
      .mul_c_i     (mul_c),
      .op_cnt_o    (op_cnt),
      .small_cnt_o (small_cnt)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
      bus.req_a[16*i +: 16] = a;
      bus.req_b[16*i +: 16] = b;
   endtask

   task automatic reset_dut();
      bus.req_valid = '0;
      bus.rsp_ready = '0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
   endtask

   // Issues one op from IDLE with the given valid mask, returns the grant seen,
   // waits (bounded) for the response and completes the handshake.
   task automatic run_op(input logic [3:0] mask, output logic [3:0] granted);
      int waited;
      bus.req_valid = mask;
      #1;
      granted = bus.req_ready;
      step();
      bus.req_valid = '0;
      waited = 0;
      while (bus.rsp_valid == 4'b0 && waited < 10) begin
         step();
         waited++;
      end
      if (waited >= 10) begin
         n_checks++;
         n_fail++;
         $display("FAIL run_op_timeout: rsp_valid=%b after %0d cycles, required nonzero", bus.rsp_valid, waited);
      end
      bus.rsp_ready = 4'hF;
      step();
      bus.rsp_ready = '0;
   endtask

   task automatic test_reset();
      bus.req_valid = '0;
      bus.rsp_ready = '0;
      bus.req_a = '0;
      bus.req_b = '0;
      rst_n = 1'b0;
      #2;
      n_checks++; if (bus.req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b required 0000", bus.req_ready); end
      n_checks++; if (bus.rsp_valid !== 4'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b required 0000", bus.rsp_valid); end
      n_checks++; if ({mul_a, mul_b} !== 32'h0) begin n_fail++; $display("FAIL reset_mul_ab: got %h required 0", {mul_a, mul_b}); end
      n_checks++; if ({bus.rsp_c, bus.rsp_tag} !== 34'h0) begin n_fail++; $display("FAIL reset_rsp: got c=%0d tag=%0d required 0", bus.rsp_c, bus.rsp_tag); end
      n_checks++; if ({op_cnt, small_cnt} !== 32'h0) begin n_fail++; $display("FAIL reset_cnt: got op=%0d small=%0d required 0", op_cnt, small_cnt); end
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      reset_dut();
      set_req(0, 16'd300, 16'd400);
      bus.req_valid = 4'b0001;
      #1;
      n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b required 0001", bus.req_ready); end
      step();
      bus.req_valid = '0;
      #1;
      n_checks++; if (bus.req_ready !== 4'b0 || bus.rsp_valid !== 4'b0) begin n_fail++; $display("FAIL single_mul_cycle: ready=%b rsp_valid=%b required 0000/0000", bus.req_ready, bus.rsp_valid); end
      step();
      n_checks++; if (bus.rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL single_rsp_valid: got %b required 0001", bus.rsp_valid); end
      n_checks++; if (bus.rsp_c !== 32'd120000) begin n_fail++; $display("FAIL single_rsp_c: got %0d required 120000", bus.rsp_c); end
      n_checks++; if (bus.rsp_tag !== 2'd0) begin n_fail++; $display("FAIL single_rsp_tag: got %0d required 0", bus.rsp_tag); end
      n_checks++; if (mul_a !== 16'd300 || mul_b !== 16'd400) begin n_fail++; $display("FAIL single_mul_ops: got %0d,%0d required 300,400", mul_a, mul_b); end
      bus.rsp_ready = 4'b0001;
      step();
      bus.rsp_ready = '0;
      n_checks++; if (bus.rsp_valid !== 4'b0) begin n_fail++; $display("FAIL single_rsp_clear: got %b required 0000", bus.rsp_valid); end
      n_checks++; if (op_cnt !== 16'd1 || small_cnt !== 16'd0) begin n_fail++; $display("FAIL single_cnt: got op=%0d small=%0d required 1/0", op_cnt, small_cnt); end
      step();
      n_checks++; if (mul_a !== 16'd300) begin n_fail++; $display("FAIL single_mul_hold: got %0d required 300", mul_a); end
   endtask

   task automatic test_fairness();
      int order [6] = '{0, 1, 2, 3, 0, 1};
      logic [3:0] exp_rdy;
      reset_dut();
      for (int i = 0; i < 4; i++) set_req(i, 16'(i + 2), 16'd10);
      bus.req_valid = 4'hF;
      bus.rsp_ready = 4'hF;
      for (int c = 0; c < 12; c++) begin
         #1;
         exp_rdy = (c % 2 == 0) ? (4'b0001 << order[c/2]) : 4'b0000;
         n_checks++; if (bus.req_ready !== exp_rdy) begin n_fail++; $display("FAIL fair_grant_c%0d: got %b required %b", c, bus.req_ready, exp_rdy); end
         if (c % 2 == 1) begin
            n_checks++; if (bus.rsp_valid !== 4'b0) begin n_fail++; $display("FAIL fair_mul_c%0d: rsp_valid=%b required 0000", c, bus.rsp_valid); end
         end else if (c >= 2) begin
            n_checks++;
            if (bus.rsp_valid !== (4'b0001 << order[c/2-1]) || bus.rsp_c !== 32'((order[c/2-1] + 2) * 10)) begin
               n_fail++;
               $display("FAIL fair_rsp_c%0d: valid=%b c=%0d required %b c=%0d", c, bus.rsp_valid, bus.rsp_c, 4'b0001 << order[c/2-1], (order[c/2-1] + 2) * 10);
            end
         end
         step();
      end
      bus.req_valid = '0;
      #1;
      n_checks++; if (bus.rsp_valid !== 4'b0010 || bus.rsp_tag !== 2'd1 || bus.rsp_c !== 32'd30 || bus.req_ready !== 4'b0) begin
         n_fail++; $display("FAIL fair_last: valid=%b tag=%0d c=%0d ready=%b required 0010/1/30/0000", bus.rsp_valid, bus.rsp_tag, bus.rsp_c, bus.req_ready); end
      step();
      bus.rsp_ready = '0;
      n_checks++; if (bus.rsp_valid !== 4'b0 || op_cnt !== 16'd6) begin n_fail++; $display("FAIL fair_end: valid=%b op=%0d required 0000/6", bus.rsp_valid, op_cnt); end
   endtask

   task automatic test_backpressure();
      reset_dut();
      set_req(2, 16'd7, 16'd9);
      bus.req_valid = 4'b0100;
      bus.rsp_ready = 4'b1011;
      #1;
      n_checks++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_grant: got %b required 0100", bus.req_ready); end
      step();
      bus.req_valid = 4'b1011;
      #1;
      n_checks++; if (bus.req_ready !== 4'b0) begin n_fail++; $display("FAIL bp_mul_ready: got %b required 0000", bus.req_ready); end
      step();
      for (int c = 0; c < 5; c++) begin
         #1;
         n_checks++;
         if (bus.rsp_valid !== 4'b0100 || bus.rsp_c !== 32'd63 || bus.rsp_tag !== 2'd2 || bus.req_ready !== 4'b0) begin
            n_fail++;
            $display("FAIL bp_hold_c%0d: valid=%b c=%0d tag=%0d ready=%b required 0100/63/2/0000", c, bus.rsp_valid, bus.rsp_c, bus.rsp_tag, bus.req_ready);
         end
         step();
      end
      bus.req_valid = '0;
      bus.rsp_ready = 4'hF;
      #1;
      n_checks++; if (bus.req_ready !== 4'b0) begin n_fail++; $display("FAIL bp_release_ready: got %b required 0000", bus.req_ready); end
      step();
      bus.rsp_ready = '0;
      n_checks++; if (bus.rsp_valid !== 4'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b required 0000", bus.rsp_valid); end
      n_checks++; if (op_cnt !== 16'd1 || small_cnt !== 16'd1) begin n_fail++; $display("FAIL bp_cnt: got op=%0d small=%0d required 1/1", op_cnt, small_cnt); end
   endtask

   task automatic test_wrap();
      logic [3:0] g;
      reset_dut();
      for (int i = 0; i < 4; i++) set_req(i, 16'd1000, 16'd1000);
      run_op(4'b0010, g);
      n_checks++; if (g !== 4'b0010) begin n_fail++; $display("FAIL wrap_g1: got %b required 0010", g); end
      run_op(4'b1001, g);
      n_checks++; if (g !== 4'b1000) begin n_fail++; $display("FAIL wrap_g3: got %b required 1000", g); end
      run_op(4'b0011, g);
      n_checks++; if (g !== 4'b0001) begin n_fail++; $display("FAIL wrap_g0: got %b required 0001", g); end
      run_op(4'b0011, g);
      n_checks++; if (g !== 4'b0010) begin n_fail++; $display("FAIL wrap_g1b: got %b required 0010", g); end
      n_checks++; if (op_cnt !== 16'd4 || small_cnt !== 16'd0) begin n_fail++; $display("FAIL wrap_cnt: got op=%0d small=%0d required 4/0", op_cnt, small_cnt); end
   endtask

   task automatic test_reset_in_mul();
      logic [3:0] g;
      reset_dut();
      set_req(0, 16'd5, 16'd5);
      run_op(4'b0001, g);
      set_req(1, 16'd1000, 16'd1000);
      bus.req_valid = 4'b0010;
      step();
      bus.req_valid = '0;
      rst_n = 1'b0;
      #1;
      n_checks++; if ({mul_a, mul_b} !== 32'h0) begin n_fail++; $display("FAIL rstmul_ops: got %0d,%0d required 0,0", mul_a, mul_b); end
      n_checks++; if (bus.rsp_valid !== 4'b0 || bus.req_ready !== 4'b0) begin n_fail++; $display("FAIL rstmul_hs: valid=%b ready=%b required 0000/0000", bus.rsp_valid, bus.req_ready); end
      n_checks++; if (bus.rsp_c !== 32'd0 || bus.rsp_tag !== 2'd0) begin n_fail++; $display("FAIL rstmul_rsp: c=%0d tag=%0d required 0/0", bus.rsp_c, bus.rsp_tag); end
      n_checks++; if (op_cnt !== 16'd0 || small_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmul_cnt: op=%0d small=%0d required 0/0", op_cnt, small_cnt); end
      step();
      rst_n = 1'b1;
      bus.rsp_ready = 4'hF;
      for (int c = 0; c < 5; c++) begin
         step();
         n_checks++; if (bus.rsp_valid !== 4'b0) begin n_fail++; $display("FAIL rstmul_norsp_c%0d: got %b required 0000", c, bus.rsp_valid); end
      end
      bus.rsp_ready = '0;
   endtask

   task automatic test_saturation();
      logic [3:0] g;
      reset_dut();
      force dut.op_cnt_q = 16'hFFFE;
      force dut.small_cnt_q = 16'hFFFE;
      #1;
      release dut.op_cnt_q;
      release dut.small_cnt_q;
      step();
      n_checks++; if (op_cnt !== 16'hFFFE || small_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_preload: op=%h small=%h required fffe/fffe", op_cnt, small_cnt); end
      set_req(0, 16'd1, 16'd1);
      run_op(4'b0001, g);
      n_checks++; if (op_cnt !== 16'hFFFF || small_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach: op=%h small=%h required ffff/ffff", op_cnt, small_cnt); end
      run_op(4'b0001, g);
      run_op(4'b0001, g);
      n_checks++; if (op_cnt !== 16'hFFFF || small_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: op=%h small=%h required ffff/ffff", op_cnt, small_cnt); end
      n_checks++; if (bus.rsp_c !== 32'd1 || g !== 4'b0001) begin n_fail++; $display("FAIL sat_product: c=%0d grant=%b required 1/0001", bus.rsp_c, g); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_wrap();
      test_reset_in_mul();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
